// File: rtl/tone_sequencer.sv
// Queued square-wave tone player: a small FIFO of {half_period, dur} notes played back in order.
// Define TONE_GAP_EN to insert GAP_TICKS silent ticks after every non-skipped note.
module tone_sequencer #(
    parameter int unsigned PER_W     = 16,
    parameter int unsigned DUR_W     = 10,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TICK_DIV  = 24000,
    parameter int unsigned GAP_TICKS = 10
) (
    input  logic                       int_osc,
    input  logic                       nreset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [PER_W-1:0]           half_period,
    input  logic [DUR_W-1:0]           dur,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       tone
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned EntW  = PER_W + DUR_W;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap
    } state_e;

    // ---------------------------------------------------------------- note FIFO
    logic [EntW-1:0]  mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [PER_W-1:0] head_per;
    logic [DUR_W-1:0] head_dur;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full && !stop;
    assign push     = wr_valid && wr_ready;
    assign count    = count_q;
    assign head_per = mem[rd_ptr][EntW-1:DUR_W];
    assign head_dur = mem[rd_ptr][DUR_W-1:0];

    always_ff @(posedge int_osc) begin
        if (push) begin
            mem[wr_ptr] <= {half_period, dur};
        end
    end

    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (stop) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- playback FSM
    state_e           state;
    logic [PER_W-1:0] per_q;
    logic [DUR_W-1:0] dur_q;
    logic [PER_W-1:0] per_cnt;
    logic [TickW-1:0] tick_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic             tick_wrap;
    logic             play_end;
    logic             decide;

`ifdef TONE_GAP_EN
    localparam int unsigned GapW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    logic [GapW-1:0] gap_cnt;
    logic            gap_end;
`else
    logic            unused_gap_cfg;
    assign unused_gap_cfg = (GAP_TICKS != 0);
`endif

    assign busy = (state != StIdle);

    always_comb begin
        tick_wrap = (tick_cnt == TickW'(TICK_DIV - 1));
        play_end  = (state == StPlay) && tick_wrap && ((dur_cnt + DUR_W'(1)) == dur_q);
`ifdef TONE_GAP_EN
        gap_end   = (state == StGap) && tick_wrap && (gap_cnt == GapW'(GAP_TICKS - 1));
        decide    = gap_end || ((state == StLoad) && (dur_q == '0));
`else
        decide    = play_end || ((state == StLoad) && (dur_q == '0));
`endif
        // Idle and every next-note decision pop the head whenever one is waiting
        pop       = !stop && !empty && ((state == StIdle) || decide);
    end

    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            state    <= StIdle;
            tone     <= 1'b0;
            done     <= 1'b0;
            per_q    <= '0;
            dur_q    <= '0;
            per_cnt  <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
`ifdef TONE_GAP_EN
            gap_cnt  <= '0;
`endif
        end else if (stop) begin
            state    <= StIdle;
            tone     <= 1'b0;
            done     <= 1'b0;
            per_cnt  <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
`ifdef TONE_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                end
                StLoad: begin
                    if (dur_q != '0) begin
                        per_cnt  <= '0;
                        tick_cnt <= '0;
                        dur_cnt  <= '0;
                        tone     <= (per_q != '0);
                        state    <= StPlay;
                    end
                end
                StPlay: begin
                    if (per_q != '0) begin
                        if (per_cnt == per_q - PER_W'(1)) begin
                            per_cnt <= '0;
                            tone    <= ~tone;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                    if (tick_wrap) begin
                        tick_cnt <= '0;
                        dur_cnt  <= dur_cnt + DUR_W'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TickW'(1);
                    end
                    // Note end overrides a coincident half-period toggle
                    if (play_end) begin
                        tone <= 1'b0;
`ifdef TONE_GAP_EN
                        state   <= StGap;
                        gap_cnt <= '0;
`endif
                    end
                end
`ifdef TONE_GAP_EN
                StGap: begin
                    if (tick_wrap) begin
                        tick_cnt <= '0;
                        gap_cnt  <= gap_cnt + GapW'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TickW'(1);
                    end
                end
`endif
                default: state <= StIdle;
            endcase

            // Next-note decision: load the head, or finish the queue
            if (pop) begin
                per_q <= head_per;
                dur_q <= head_dur;
                tone  <= 1'b0;
                state <= StLoad;
            end else if (decide) begin
                tone  <= 1'b0;
                done  <= 1'b1;
                state <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenarios plus random traffic against a
// queue-and-waveform reference model. Works with or without TONE_GAP_EN defined.
module tb_tone_sequencer;

    localparam int PER_W     = 8;
    localparam int DUR_W     = 4;
    localparam int DEPTH     = 2;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 2;
    localparam int CNT_W     = $clog2(DEPTH + 1);
`ifdef TONE_GAP_EN
    localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
`else
    localparam int GAP_CYC = 0;
`endif

    logic             clk = 1'b0;
    logic             nreset = 1'b1;
    logic             wr_valid = 1'b0;
    logic             stop = 1'b0;
    logic [PER_W-1:0] half_period = '0;
    logic [DUR_W-1:0] dur = '0;
    logic             wr_ready;
    logic             busy;
    logic             done;
    logic             tone;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    tone_sequencer #(
        .PER_W    (PER_W),
        .DUR_W    (DUR_W),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .int_osc    (clk),
        .nreset     (nreset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .half_period(half_period),
        .dur        (dur),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .tone       (tone)
    );

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int busy_cycles = 0;

    // Reference model: queued notes, plus the per-cycle tone values still to come for the
    // note in progress (load cycle, play cycles, optional silent gap).
    typedef struct {
        int hp;
        int d;
    } note_t;
    note_t mq[$];
    int    plan[$];
    bit    m_busy = 0;
    bit    m_done = 0;
    bit    m_tone = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        plan.delete();
        m_busy = 0;
        m_done = 0;
        m_tone = 0;
    endfunction

    function automatic void build(input note_t n);
        plan.push_back(0);
        if (n.d > 0) begin
            for (int k = 0; k < n.d * TICK_DIV; k++) begin
                plan.push_back((n.hp != 0 && ((k / n.hp) % 2) == 0) ? 1 : 0);
            end
            for (int k = 0; k < GAP_CYC; k++) plan.push_back(0);
        end
    endfunction

    function automatic void model_edge(input bit acc);
        note_t n;
        if (stop) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (plan.size() == 0) begin
            if (mq.size() > 0) begin
                n = mq.pop_front();
                build(n);
            end else begin
                m_done = m_busy;
                m_busy = 0;
                m_tone = 0;
            end
        end
        if (plan.size() > 0) begin
            m_tone = plan.pop_front() != 0;
            m_busy = 1;
        end
        if (acc) begin
            n.hp = int'(half_period);
            n.d  = int'(dur);
            mq.push_back(n);
        end
    endfunction

    task automatic drive(input bit v, input int hp, input int d, input bit s);
        wr_valid    = v;
        half_period = PER_W'(hp);
        dur         = DUR_W'(d);
        stop        = s;
    endtask

    // One clock: check wr_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        bit exp_ready;
        #1;
        exp_ready = (mq.size() < DEPTH) && !stop;
        chk("wr_ready", wr_ready, exp_ready);
        @(posedge clk);
        model_edge(wr_valid && exp_ready);
        #1;
        chk("tone", tone, m_tone);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("count", count, mq.size());
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic push_note(input int hp, input int d, output bit waited);
        bit accepted;
        accepted = 0;
        waited   = 0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            drive(1, hp, d, 0);
            if (mq.size() < DEPTH) accepted = 1;
            else waited = 1;
            step();
        end
        drive(0, 0, 0, 0);
        chk("push_timeout", accepted, 1);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        drive(0, 0, 0, 0);
        for (int i = 0; i < budget && (m_busy || mq.size() > 0); i++) step();
        chk("drain_timeout", (m_busy || mq.size() > 0) ? 1 : 0, 0);
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tone"}, tone, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_count"}, count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;

        // Reset
        #2 nreset = 1'b0;
        #10;
        check_reset_values("reset");
        @(negedge clk);
        nreset = 1'b1;
        idle(2);

        // Single note {3,2}
        done_seen = 0;
        push_note(3, 2, w);
        drain(100);
        chk("single_done_pulses", done_seen, 1);

        // Back-to-back notes until the FIFO fills; the last write must stall
        done_seen = 0;
        push_note(1, 1, w);
        push_note(2, 1, w);
        push_note(3, 1, w);
        push_note(1, 2, w);
        chk("fill_last_waited", w, 1);
        drain(400);
        chk("fill_done_pulses", done_seen, 1);

        // Rest then a short tone
        done_seen = 0;
        push_note(0, 3, w);
        push_note(2, 1, w);
        drain(200);
        chk("rest_done_pulses", done_seen, 1);

        // Zero-duration note is skipped
        done_seen   = 0;
        busy_cycles = 0;
        push_note(5, 0, w);
        drain(50);
        chk("skip_done_pulses", done_seen, 1);
        chk("skip_busy_1to2", (busy_cycles >= 1 && busy_cycles <= 2) ? 1 : 0, 1);

        // Stop mid-note with one note queued and a simultaneous write
        push_note(4, 3, w);
        push_note(2, 2, w);
        idle(6);
        drive(1, 7, 1, 1);
        step();
        drive(0, 0, 0, 0);
        chk("stop_count", count, 0);
        chk("stop_busy", busy, 0);
        chk("stop_tone", tone, 0);
        done_seen = 0;
        idle(8);
        chk("stop_no_done", done_seen, 0);

        // Asynchronous reset mid-note (mid-gap when the gap is enabled)
        push_note(2, 1, w);
        push_note(2, 1, w);
        idle(9);
        chk("pre_reset_busy", busy, 1);
        #3 nreset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        idle(3);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3),
                  $urandom_range(0, 39) == 0);
            step();
        end
        drain(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
